// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and sizing helpers for the serial adder
// Optional feature macro: ADDER_OVERFLOW_EN (see thirty_two_bit_serial_adder).
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DIGIT = 8;

   function automatic int cnt_width(input int width, input int digit);
      int w;
      w = $clog2(width / digit);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/thirty_two_bit_serial_adder_full_adder.sv
// rtl/thirty_two_bit_serial_adder_full_adder.sv - 1-bit full adder cell for the slice chain
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/thirty_two_bit_serial_adder.sv
// rtl/thirty_two_bit_serial_adder.sv - multi-cycle adder, DIGIT bits per clock
// Define ADDER_OVERFLOW_EN to compute signed overflow; otherwise overflow is tied low.
module thirty_two_bit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(WIDTH, DIGIT);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic [DIGIT-1:0] w_a_slice;
   logic [DIGIT-1:0] w_b_slice;
   logic [DIGIT-1:0] w_s_slice;
   logic [DIGIT:0]   w_c;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_accept;
   logic             w_last;

   assign w_a_slice = r_a[r_cnt*DIGIT +: DIGIT];
   assign w_b_slice = r_b[r_cnt*DIGIT +: DIGIT];
   assign w_c[0]    = r_carry;

   genvar g;
   generate
      for (g = 0; g < DIGIT; g++) begin : g_chain
         full_adder u_fa (
            .i_a    (w_a_slice[g]),
            .i_b    (w_b_slice[g]),
            .i_cin  (w_c[g]),
            .o_sum  (w_s_slice[g]),
            .o_cout (w_c[g+1])
         );
      end
   endgenerate

   // Merging the current slice here lets the final edge publish the complete sum.
   always_comb begin
      w_acc_next = r_acc;
      w_acc_next[r_cnt*DIGIT +: DIGIT] = w_s_slice;
   end

   assign w_accept = start && (r_state == IDLE || r_state == DONE);
   assign w_last   = (r_cnt == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_acc   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_carry <= w_c[DIGIT];
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_sum   <= w_acc_next;
                  r_cout  <= w_c[DIGIT];
`ifdef ADDER_OVERFLOW_EN
                  r_ovf   <= w_c[DIGIT-1] ^ w_c[DIGIT];
`else
                  r_ovf   <= 1'b0;
`endif
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_thirty_two_bit_serial_adder.sv
// tb/tb_thirty_two_bit_serial_adder.sv - directed-vector bench for thirty_two_bit_serial_adder
module tb_thirty_two_bit_serial_adder;

`ifdef ADDER_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [31:0] sum;
   logic        cout;
   logic        overflow;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   thirty_two_bit_serial_adder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .A        (a),
      .B        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns cycles advanced until done is seen (0 on timeout).
   task automatic wait_done(output int waited);
      waited = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (done) begin
            waited = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic [31:0] es, input logic ec, input logic eo);
      int w;
      start = 1'b1; a = va; b = vb; cin = vc;
      tick();
      start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h5A5A_A5A5; cin = ~vc;
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      wait_done(w);
      chk({tag, ".latency"}, w, 32'd4);
      chk({tag, ".sum"}, sum, es);
      chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
      chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
      chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
      tick();
      chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
      chk({tag, ".hold"}, sum, es);
   endtask

   initial begin
      int w1;
      int w2;
      logic seen;

      rst_n = 1'b0; start = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b1;
      tick();
      tick();
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.sum", sum, 32'd0);
      chk("rst.cout_ovf", {30'd0, cout, overflow}, 32'd0);
      rst_n = 1'b1; start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      chk("idle.quiet", {31'd0, seen}, 32'd0);

      run_op("one_plus_one", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
      run_op("ripple_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      run_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_EN);

      // Back-to-back with start held through DONE and disturbed during RUN.
      start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0;
      tick();
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; cin = 1'b1;
      tick();
      start = 1'b1; a = 32'h0BAD_F00D; b = 32'h1;
      tick();
      a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
      wait_done(w1);
      chk("b2b.first_seen", {31'd0, (w1 != 0)}, 32'd1);
      chk("b2b.sum1", sum, 32'h2345_6789);
      chk("b2b.cout1", {31'd0, cout}, 32'd0);
      tick();
      start = 1'b0; a = 32'h0; b = 32'h0;
      chk("b2b.rebusy", {31'd0, busy}, 32'd1);
      wait_done(w2);
      chk("b2b.spacing", 32'(1 + w2), 32'd5);
      chk("b2b.sum2", sum, 32'h0000_0000);
      chk("b2b.cout2", {31'd0, cout}, 32'd1);
      chk("b2b.ovf2", {31'd0, overflow}, {31'd0, OVF_EN});
      tick();

      // Leave a nonzero result, then abort a new operation with reset.
      run_op("pre_abort", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_EN);
      start = 1'b1; a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort.sum", sum, 32'd0);
      chk("abort.flags", {29'd0, busy, cout, overflow}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("abort.no_done", {31'd0, seen}, 32'd0);
      run_op("after_abort", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
